vector_mem_unit: RTL

- Sequences VLD/VST vector memory traffic for the CVP14 vector datapath.
- Sits directly downstream of the vector ALU, which produces the 16-bit effective address on result[15:0].
- Splits one 256-bit vector register (16 lanes x 16 bits) into 16 single-word memory accesses, or assembles 16 loaded words into one 256-bit vector for writeback.

---
 rtl/vector_mem_unit_if.sv | 42 ++++
 rtl/vector_mem_unit.sv | 129 ++++++++++++
 2 files changed

// File: rtl/vector_mem_unit_if.sv
// vector_mem_unit_if: execute-stage request and single-word memory port bundle for vector_mem_unit.
// The stride signal exists only when VMU_STRIDE_EN is defined.
interface vector_mem_unit_if #(
  parameter int NUM_ELEMS = 16,
  parameter int ELEM_W    = 16,
  parameter int ADDR_W    = 16
);
  logic                          start;
  logic                          is_store;
  logic [ADDR_W-1:0]             base_addr;
`ifdef VMU_STRIDE_EN
  logic [ADDR_W-1:0]             stride;
`endif
  logic [NUM_ELEMS*ELEM_W-1:0]   st_data;
  logic                          busy;
  logic                          done;
  logic [NUM_ELEMS*ELEM_W-1:0]   ld_data;
  logic                          mem_re;
  logic                          mem_we;
  logic [ADDR_W-1:0]             mem_addr;
  logic [ELEM_W-1:0]             mem_wdata;
  logic [ELEM_W-1:0]             mem_rdata;
  logic                          mem_ack;

  modport master (
    output start, is_store, base_addr,
`ifdef VMU_STRIDE_EN
    output stride,
`endif
    output st_data, mem_rdata, mem_ack,
    input  busy, done, ld_data, mem_re, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  start, is_store, base_addr,
`ifdef VMU_STRIDE_EN
    input  stride,
`endif
    input  st_data, mem_rdata, mem_ack,
    output busy, done, ld_data, mem_re, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vector_mem_unit.sv
// vector_mem_unit: splits a VLD/VST vector into per-lane memory word accesses and assembles loads.
// Optional VMU_STRIDE_EN adds a latched element stride; otherwise elements are consecutive words.
module vector_mem_unit #(
  parameter int NUM_ELEMS = 16,
  parameter int ELEM_W    = 16,
  parameter int ADDR_W    = 16
) (
  input logic clk,
  input logic rst_n,
  vector_mem_unit_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_ELEMS);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t                              state_q, state_d;
  logic [IDX_W-1:0]                    idx_q, idx_d, idx_nx;
  logic                                store_q, store_d;
  logic [NUM_ELEMS-1:0][ELEM_W-1:0]    st_q, st_d;
  logic [NUM_ELEMS-1:0][ELEM_W-1:0]    ld_q, ld_d;
  logic [ADDR_W-1:0]                   addr_q, addr_d, step;
  logic [ELEM_W-1:0]                   wdata_q, wdata_d;
  logic                                busy_q, busy_d;
  logic                                done_q, done_d;
  logic                                re_q, re_d;
  logic                                we_q, we_d;
  logic                                last;
`ifdef VMU_STRIDE_EN
  logic [ADDR_W-1:0]                   stride_q, stride_d;
  assign step = stride_q;
`else
  assign step = ADDR_W'(1);
`endif

  assign idx_nx = idx_q + 1'b1;
  assign last   = idx_q == IDX_W'(NUM_ELEMS - 1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    store_d = store_q;
    st_d    = st_q;
    ld_d    = ld_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    re_d    = re_q;
    we_d    = we_q;
`ifdef VMU_STRIDE_EN
    stride_d = stride_q;
`endif
    unique case (state_q)
      IDLE: if (bus.start) begin
        state_d = XFER;
        busy_d  = 1'b1;
        store_d = bus.is_store;
        st_d    = bus.st_data;
        ld_d    = '0;
        idx_d   = '0;
        addr_d  = bus.base_addr;
        wdata_d = bus.st_data[ELEM_W-1:0];
        re_d    = !bus.is_store;
        we_d    = bus.is_store;
`ifdef VMU_STRIDE_EN
        stride_d = bus.stride;
`endif
      end
      // the request stays frozen until acked; the last ack drops it and moves to DONE
      XFER: if (bus.mem_ack) begin
        if (!store_q) ld_d[idx_q] = bus.mem_rdata;
        idx_d   = last ? idx_q : idx_nx;
        addr_d  = last ? addr_q : addr_q + step;
        wdata_d = last ? wdata_q : st_q[idx_nx];
        re_d    = re_q && !last;
        we_d    = we_q && !last;
        done_d  = last;
        state_d = last ? DONE : XFER;
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      store_q <= 1'b0;
      st_q    <= '0;
      ld_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
`ifdef VMU_STRIDE_EN
      stride_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      store_q <= store_d;
      st_q    <= st_d;
      ld_q    <= ld_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      re_q    <= re_d;
      we_q    <= we_d;
`ifdef VMU_STRIDE_EN
      stride_q <= stride_d;
`endif
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.ld_data   = ld_q;
  assign bus.mem_re    = re_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
endmodule
